view_ctrl: RTL and testbench

VIEW_CTRL -- requirements
Module: view_ctrl

---
 rtl/view_ctrl_pkg.sv | 32 +++
 rtl/startup_seq.sv | 46 ++++
 rtl/view_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_view_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/view_ctrl_pkg.sv
// Shared types and default constants for the view controller.
package view_ctrl_pkg;

  typedef enum logic [1:0] {
    KEY_WAIT   = 2'd0,
    KEY_SAMPLE = 2'd1,
    KEY_HELD   = 2'd2
  } key_state_e;

  // Pressed-button view (active-high after inversion of the pins)
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic zin;
    logic zout;
  } btn_t;

  localparam int unsigned DEF_COORD_W       = 10;
  localparam int unsigned DEF_STEP          = 2;
  localparam int unsigned DEF_X0            = 300;
  localparam int unsigned DEF_Y0            = 200;
  localparam int unsigned DEF_X_MAX         = 639;
  localparam int unsigned DEF_Y_MAX         = 479;
  localparam int unsigned DEF_ZOOM_W        = 3;
  localparam int unsigned DEF_ZOOM_MAX      = 5;
  localparam int unsigned DEF_DISP_DELAY    = 6;
  localparam int unsigned DEF_CALC_DELAY    = 15;
  localparam int unsigned DEF_REPEAT_FRAMES = 8;

endpackage

// File: rtl/startup_seq.sv
// Tick-driven startup sequencer: raises display then calculator enables
// and freezes once the later threshold is reached.
module startup_seq
  import view_ctrl_pkg::*;
#(
  parameter int unsigned DISP_DELAY = DEF_DISP_DELAY,
  parameter int unsigned CALC_DELAY = DEF_CALC_DELAY
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  output logic disp_enable,
  output logic calc_enable
);

  localparam int unsigned CNT_W = $clog2(CALC_DELAY + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             disp_q, disp_d;
  logic             calc_q, calc_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick && (cnt_q < CNT_W'(CALC_DELAY))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    disp_d = (cnt_d >= CNT_W'(DISP_DELAY));
    calc_d = (cnt_d == CNT_W'(CALC_DELAY));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q  <= '0;
      disp_q <= 1'b0;
      calc_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
      calc_q <= calc_d;
    end
  end

  assign disp_enable = disp_q;
  assign calc_enable = calc_q;

endmodule

// File: rtl/view_ctrl.sv
// View controller: startup gating, pixel colour register and once-per-blanking
// pan/zoom key handling. Define VIEW_CTRL_AUTOREPEAT_EN for held-key autorepeat.
module view_ctrl
  import view_ctrl_pkg::*;
#(
  parameter int unsigned COORD_W       = DEF_COORD_W,
  parameter int unsigned STEP          = DEF_STEP,
  parameter int unsigned X0            = DEF_X0,
  parameter int unsigned Y0            = DEF_Y0,
  parameter int unsigned X_MAX         = DEF_X_MAX,
  parameter int unsigned Y_MAX         = DEF_Y_MAX,
  parameter int unsigned ZOOM_W        = DEF_ZOOM_W,
  parameter int unsigned ZOOM_MAX      = DEF_ZOOM_MAX,
  parameter int unsigned DISP_DELAY    = DEF_DISP_DELAY,
  parameter int unsigned CALC_DELAY    = DEF_CALC_DELAY,
  parameter int unsigned REPEAT_FRAMES = DEF_REPEAT_FRAMES
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               tick,
  input  logic               vnotactive,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               zin,
  input  logic               zout,
  input  logic               red_in,
  input  logic               green_in,
  input  logic               blue_in,
  output logic               red,
  output logic               green,
  output logic               blue,
  output logic [COORD_W-1:0] origin_x,
  output logic [COORD_W-1:0] origin_y,
  output logic [ZOOM_W-1:0]  zoom,
  output logic               disp_enable,
  output logic               calc_enable
);

  localparam int unsigned EXT_W = COORD_W + 1;

  key_state_e         state_q, state_d;
  btn_t               pressed_c;
  logic               any_c;
  logic               sample_c;
  logic               fire_c;
  logic [COORD_W-1:0] origin_x_q, origin_x_d;
  logic [COORD_W-1:0] origin_y_q, origin_y_d;
  logic [ZOOM_W-1:0]  zoom_q, zoom_d;
  logic               red_q, green_q, blue_q;

  startup_seq #(
    .DISP_DELAY (DISP_DELAY),
    .CALC_DELAY (CALC_DELAY)
  ) u_startup (
    .CLK         (CLK),
    .RST         (RST),
    .tick        (tick),
    .disp_enable (disp_enable),
    .calc_enable (calc_enable)
  );

  // Colour holds at white until the display is enabled
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      red_q   <= 1'b1;
      green_q <= 1'b1;
      blue_q  <= 1'b1;
    end else if (disp_enable) begin
      red_q   <= red_in;
      green_q <= green_in;
      blue_q  <= blue_in;
    end
  end

  assign pressed_c = btn_t'(~{up, down, left, right, zin, zout});
  assign any_c     = |pressed_c;

  always_comb begin
    state_d  = state_q;
    sample_c = 1'b0;
    case (state_q)
      KEY_WAIT: begin
        if (vnotactive) state_d = KEY_SAMPLE;
      end
      KEY_SAMPLE: begin
        sample_c = 1'b1;
        if (any_c)            state_d = KEY_HELD;
        else if (!vnotactive) state_d = KEY_WAIT;
      end
      KEY_HELD: begin
        if (!vnotactive) state_d = KEY_WAIT;
      end
      default: state_d = KEY_WAIT;
    endcase
  end

`ifdef VIEW_CTRL_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_FRAMES + 1);

  logic [REP_W-1:0] rep_q, rep_d;
  btn_t             prev_q, prev_d;

  // A new button set fires at once; an unchanged set fires only after the hold run
  always_comb begin
    rep_d  = rep_q;
    prev_d = prev_q;
    fire_c = 1'b0;
    if (sample_c) begin
      prev_d = pressed_c;
      if (!any_c) begin
        rep_d = '0;
      end else if (pressed_c != prev_q) begin
        rep_d  = '0;
        fire_c = 1'b1;
      end else begin
        if (rep_q < REP_W'(REPEAT_FRAMES)) rep_d = rep_q + REP_W'(1);
        fire_c = (rep_d == REP_W'(REPEAT_FRAMES));
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rep_q  <= '0;
      prev_q <= '0;
    end else begin
      rep_q  <= rep_d;
      prev_q <= prev_d;
    end
  end
`else
  logic unused_repeat_c;
  assign unused_repeat_c = ^32'(REPEAT_FRAMES);
  assign fire_c          = 1'b1;
`endif

  function automatic logic [COORD_W-1:0] sat_dec(input logic [COORD_W-1:0] v);
    return (v < COORD_W'(STEP)) ? '0 : v - COORD_W'(STEP);
  endfunction

  // Sum is formed one bit wider so a ceiling near 2**COORD_W cannot wrap
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v,
                                                 input logic [EXT_W-1:0]   lim);
    logic [EXT_W-1:0] sum;
    sum = {1'b0, v} + EXT_W'(STEP);
    return (sum > lim) ? COORD_W'(lim) : v + COORD_W'(STEP);
  endfunction

  always_comb begin
    origin_x_d = origin_x_q;
    origin_y_d = origin_y_q;
    zoom_d     = zoom_q;
    if (sample_c && any_c && fire_c) begin
      if (pressed_c.up)         origin_y_d = sat_dec(origin_y_q);
      else if (pressed_c.down)  origin_y_d = sat_inc(origin_y_q, EXT_W'(Y_MAX));
      if (pressed_c.left)       origin_x_d = sat_dec(origin_x_q);
      else if (pressed_c.right) origin_x_d = sat_inc(origin_x_q, EXT_W'(X_MAX));
      if (pressed_c.zin) begin
        zoom_d = (zoom_q >= ZOOM_W'(ZOOM_MAX)) ? ZOOM_W'(ZOOM_MAX) : zoom_q + ZOOM_W'(1);
      end else if (pressed_c.zout) begin
        zoom_d = (zoom_q == '0) ? '0 : zoom_q - ZOOM_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= KEY_WAIT;
      origin_x_q <= COORD_W'(X0);
      origin_y_q <= COORD_W'(Y0);
      zoom_q     <= '0;
    end else begin
      state_q    <= state_d;
      origin_x_q <= origin_x_d;
      origin_y_q <= origin_y_d;
      zoom_q     <= zoom_d;
    end
  end

  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign origin_x = origin_x_q;
  assign origin_y = origin_y_q;
  assign zoom     = zoom_q;

endmodule

// File: tb/tb_view_ctrl.sv
// Directed bench for view_ctrl: startup gating, colour pipeline, pan/zoom
// vector table, saturation at both bounds, mid-run reset and held keys.
module tb_view_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       tick, vnotactive;
  logic       up, down, left, right, zin, zout;
  logic [5:0] btn2_n;
  logic       red_in, green_in, blue_in;
  logic       red, green, blue;
  logic [9:0] origin_x, origin_y;
  logic [2:0] zoom;
  logic       disp_enable, calc_enable;
  logic       red2, green2, blue2;
  logic [9:0] origin_x2, origin_y2;
  logic [2:0] zoom2;
  logic       disp_enable2, calc_enable2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] btn_n;
    int         x;
    int         y;
    int         z;
  } vec_t;

  vec_t vecs[15];

  always #5 CLK = ~CLK;

  view_ctrl dut (
    .CLK(CLK), .RST(RST), .tick(tick), .vnotactive(vnotactive),
    .up(up), .down(down), .left(left), .right(right), .zin(zin), .zout(zout),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red(red), .green(green), .blue(blue),
    .origin_x(origin_x), .origin_y(origin_y), .zoom(zoom),
    .disp_enable(disp_enable), .calc_enable(calc_enable)
  );

  view_ctrl #(.X0(1), .Y0(478)) dut2 (
    .CLK(CLK), .RST(RST), .tick(tick), .vnotactive(vnotactive),
    .up(btn2_n[5]), .down(btn2_n[4]), .left(btn2_n[3]), .right(btn2_n[2]),
    .zin(btn2_n[1]), .zout(btn2_n[0]),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red(red2), .green(green2), .blue(blue2),
    .origin_x(origin_x2), .origin_y(origin_y2), .zoom(zoom2),
    .disp_enable(disp_enable2), .calc_enable(calc_enable2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic set_btn(input logic [5:0] b);
    {up, down, left, right, zin, zout} = b;
  endtask

  // One vertical blanking interval followed by active video
  task automatic blank_interval();
    vnotactive = 1'b1;
    repeat (3) step();
    vnotactive = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    int exp_x;
    vecs[0]  = '{6'b011111, 300, 198, 0};
    vecs[1]  = '{6'b011111, 300, 196, 0};
    vecs[2]  = '{6'b011111, 300, 194, 0};
    vecs[3]  = '{6'b001111, 300, 192, 0};
    vecs[4]  = '{6'b111100, 300, 192, 1};
    vecs[5]  = '{6'b110111, 298, 192, 1};
    vecs[6]  = '{6'b111011, 300, 192, 1};
    vecs[7]  = '{6'b111101, 300, 192, 2};
    vecs[8]  = '{6'b111101, 300, 192, 3};
    vecs[9]  = '{6'b111101, 300, 192, 4};
    vecs[10] = '{6'b111101, 300, 192, 5};
    vecs[11] = '{6'b111101, 300, 192, 5};
    vecs[12] = '{6'b111110, 300, 192, 4};
    vecs[13] = '{6'b111111, 300, 192, 4};
    vecs[14] = '{6'b000000, 298, 190, 5};

    RST = 1'b0; tick = 1'b0; vnotactive = 1'b0;
    set_btn(6'b111111); btn2_n = 6'b111111;
    red_in = 1'b1; green_in = 1'b1; blue_in = 1'b1;
    step(); step();
    RST = 1'b1;
    step();

    chk("rst_red", int'(red), 1);
    chk("rst_green", int'(green), 1);
    chk("rst_blue", int'(blue), 1);
    chk("rst_x", int'(origin_x), 300);
    chk("rst_y", int'(origin_y), 200);
    chk("rst_zoom", int'(zoom), 0);
    chk("rst_disp", int'(disp_enable), 0);
    chk("rst_calc", int'(calc_enable), 0);

    // Colour must hold while display is disabled
    red_in = 1'b0;
    step();
    chk("pre_en_red", int'(red), 1);
    red_in = 1'b1;

    for (int i = 1; i <= 20; i++) begin
      pulse_tick();
      if (i == 5)  chk("disp_at5", int'(disp_enable), 0);
      if (i == 6)  chk("disp_at6", int'(disp_enable), 1);
      if (i == 14) chk("calc_at14", int'(calc_enable), 0);
      if (i == 15) chk("calc_at15", int'(calc_enable), 1);
      if (i == 20) begin
        chk("disp_at20", int'(disp_enable), 1);
        chk("calc_at20", int'(calc_enable), 1);
      end
    end

    // One-cycle colour latency once enabled
    red_in = 1'b0;
    chk("post_en_red_old", int'(red), 1);
    step();
    chk("post_en_red_new", int'(red), 0);
    red_in = 1'b1; green_in = 1'b0;
    step();
    chk("post_en_red_back", int'(red), 1);
    chk("post_en_green", int'(green), 0);
    green_in = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      set_btn(vecs[i].btn_n);
      blank_interval();
      chk($sformatf("row%0d_x", i), int'(origin_x), vecs[i].x);
      chk($sformatf("row%0d_y", i), int'(origin_y), vecs[i].y);
      chk($sformatf("row%0d_zoom", i), int'(zoom), vecs[i].z);
`ifdef VIEW_CTRL_AUTOREPEAT_EN
      set_btn(6'b111111);
      blank_interval();
`endif
    end
    set_btn(6'b111111);

    // Saturation at zero and at the Y ceiling on the second instance
    btn2_n = 6'b110111;
    blank_interval();
    chk("sat_x_zero_1", int'(origin_x2), 0);
    blank_interval();
    chk("sat_x_zero_2", int'(origin_x2), 0);
    btn2_n = 6'b101111;
    blank_interval();
    chk("sat_y_max_1", int'(origin_y2), 479);
    blank_interval();
    chk("sat_y_max_2", int'(origin_y2), 479);
    chk("sat_x_still0", int'(origin_x2), 0);
    btn2_n = 6'b111111;

    // Asynchronous reset mid-operation
    #3 RST = 1'b0;
    #2;
    chk("mid_rst_disp", int'(disp_enable), 0);
    chk("mid_rst_calc", int'(calc_enable), 0);
    chk("mid_rst_x", int'(origin_x), 300);
    chk("mid_rst_y", int'(origin_y), 200);
    chk("mid_rst_zoom", int'(zoom), 0);
    step();
    RST = 1'b1;
    step();
    for (int i = 1; i <= 6; i++) begin
      pulse_tick();
      if (i == 5) chk("restart_disp5", int'(disp_enable), 0);
      if (i == 6) chk("restart_disp6", int'(disp_enable), 1);
    end
    chk("restart_calc", int'(calc_enable), 0);

    // Right held across consecutive intervals
    set_btn(6'b111011);
`ifdef VIEW_CTRL_AUTOREPEAT_EN
    for (int i = 1; i <= 10; i++) begin
      blank_interval();
      exp_x = (i < 9) ? 302 : 302 + 2 * (i - 8);
      chk($sformatf("rep_int%0d_x", i), int'(origin_x), exp_x);
    end
`else
    for (int i = 1; i <= 3; i++) begin
      blank_interval();
      exp_x = 300 + 2 * i;
      chk($sformatf("hold_int%0d_x", i), int'(origin_x), exp_x);
    end
`endif
    set_btn(6'b111111);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
